// File: rtl/axis_ramp_gen.sv
// axis_ramp_gen: AXI4-Stream source of a Y x X byte-ramp frame, SOF/EOF/SOL/EOL sync in tuser.
// Build option AXIS_RAMP_GEN_ROWID_EN: byte 0 of each row's first beat carries row index[7:0].
//
// state  | meaning
// IDLE   | waiting for start; config latched on start
// LOAD   | one cycle: row bytes / beat count computed, first beat prepared
// SEND   | presenting beats of the current row
// GAP    | line_gap idle cycles (tvalid=0) between rows
// DONE   | one-cycle done pulse, back to IDLE
module axis_ramp_gen #(
    parameter int MAX_X_BYTES = 65536,
    parameter int GAP_W       = 8
) (
    input  logic             aclk,
    input  logic             aclk_reset_n,
    input  logic             aclk_start,
    input  logic [2:0]       aclk_pixel_width,
    input  logic [15:0]      aclk_x_size,
    input  logic [15:0]      aclk_y_size,
    input  logic [GAP_W-1:0] aclk_line_gap,
    output logic             aclk_busy,
    output logic             aclk_done,
    input  logic             aclk_tready,
    output logic             aclk_tvalid,
    output logic [63:0]      aclk_tdata,
    output logic [3:0]       aclk_tuser,
    output logic             aclk_tlast
);

    // Row length is x_size * (1 or 2), so the byte counter needs one bit above MAX_X_BYTES.
    localparam int BYTE_W = $clog2(MAX_X_BYTES) + 1;
    localparam int BEAT_W = BYTE_W - 2;

`ifdef AXIS_RAMP_GEN_ROWID_EN
    localparam bit ROWID_EN = 1'b1;
`else
    localparam bit ROWID_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_pw2;
    logic [15:0]        r_x_size;
    logic [15:0]        r_y_size;
    logic [GAP_W-1:0]   r_line_gap;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [BYTE_W-1:0]  r_rb;
    logic [BEAT_W-1:0]  r_nb;
    logic [BEAT_W-1:0]  r_beat;
    logic [15:0]        r_row;
    logic               r_busy;
    logic               r_done;
    logic               r_tvalid;
    logic [63:0]        r_tdata;
    logic [3:0]         r_tuser;
    logic               r_tlast;

    logic [16:0]        w_rb_full;
    logic [BYTE_W-1:0]  w_rb;
    logic [BYTE_W:0]    w_nb_sum;
    logic [BEAT_W-1:0]  w_nb;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic [15:0]        w_row_nxt;
    logic               w_row_end;
    logic               w_last_row;

    assign w_rb_full  = r_pw2 ? {r_x_size, 1'b0} : {1'b0, r_x_size};
    assign w_rb       = BYTE_W'(w_rb_full);
    assign w_nb_sum   = {1'b0, w_rb} + (BYTE_W + 1)'(7);
    assign w_nb       = w_nb_sum[BYTE_W:3];
    assign w_beat_nxt = r_beat + BEAT_W'(1);
    assign w_row_nxt  = r_row + 16'd1;
    assign w_row_end  = (r_beat == r_nb - BEAT_W'(1));
    assign w_last_row = (r_row == r_y_size - 16'd1);

    // Byte k of a row is k[7:0]; bytes past the row end pad the final beat with zero.
    function automatic logic [63:0] f_data(input logic [BEAT_W-1:0] beat,
                                           input logic [7:0]        row_lo,
                                           input logic [BYTE_W-1:0] rb);
        logic [BEAT_W+2:0] idx;
        logic [63:0]       d;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            idx = {beat, 3'(i)};
            if (idx < (BEAT_W + 3)'(rb)) d[8*i +: 8] = idx[7:0];
        end
        if (ROWID_EN && beat == BEAT_W'(0)) d[7:0] = row_lo;
        return d;
    endfunction

    // Returns {tlast, tuser}; a single-beat row gets both its start and end bits.
    function automatic logic [4:0] f_sync(input logic [BEAT_W-1:0] beat,
                                          input logic [15:0]       row,
                                          input logic [BEAT_W-1:0] nb,
                                          input logic [15:0]       ny);
        logic first, last, last_row;
        first    = (beat == BEAT_W'(0));
        last     = (beat == nb - BEAT_W'(1));
        last_row = (row == ny - 16'd1);
        return {last, last & ~last_row, first & (row != 16'd0), last & last_row,
                first & (row == 16'd0)};
    endfunction

    always_ff @(posedge aclk or negedge aclk_reset_n) begin
        if (!aclk_reset_n) begin
            r_state    <= S_IDLE;
            r_pw2      <= 1'b0;
            r_x_size   <= '0;
            r_y_size   <= '0;
            r_line_gap <= '0;
            r_gap_cnt  <= '0;
            r_rb       <= '0;
            r_nb       <= '0;
            r_beat     <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tuser    <= '0;
            r_tlast    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (aclk_start) begin
                        r_pw2      <= (aclk_pixel_width == 3'd2);
                        r_x_size   <= aclk_x_size;
                        r_y_size   <= aclk_y_size;
                        r_line_gap <= aclk_line_gap;
                        if (aclk_x_size == 16'd0 || aclk_y_size == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    r_rb                <= w_rb;
                    r_nb                <= w_nb;
                    r_beat              <= '0;
                    r_row               <= '0;
                    r_tvalid            <= 1'b1;
                    r_tdata             <= f_data(BEAT_W'(0), 8'h00, w_rb);
                    {r_tlast, r_tuser}  <= f_sync(BEAT_W'(0), 16'd0, w_nb, r_y_size);
                    r_state             <= S_SEND;
                end

                S_SEND: begin
                    if (aclk_tready) begin
                        if (!w_row_end) begin
                            r_beat             <= w_beat_nxt;
                            r_tdata            <= f_data(w_beat_nxt, r_row[7:0], r_rb);
                            {r_tlast, r_tuser} <= f_sync(w_beat_nxt, r_row, r_nb, r_y_size);
                        end else if (w_last_row) begin
                            r_state  <= S_DONE;
                            r_beat   <= '0;
                            r_row    <= '0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_tvalid <= 1'b0;
                            r_tdata  <= '0;
                            r_tuser  <= '0;
                            r_tlast  <= 1'b0;
                        end else begin
                            r_beat <= '0;
                            r_row  <= w_row_nxt;
                            if (r_line_gap != '0) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= r_line_gap;
                                r_tvalid  <= 1'b0;
                                r_tdata   <= '0;
                                r_tuser   <= '0;
                                r_tlast   <= 1'b0;
                            end else begin
                                r_tdata            <= f_data(BEAT_W'(0), w_row_nxt[7:0], r_rb);
                                {r_tlast, r_tuser} <= f_sync(BEAT_W'(0), w_row_nxt, r_nb,
                                                             r_y_size);
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_state            <= S_SEND;
                        r_tvalid           <= 1'b1;
                        r_tdata            <= f_data(r_beat, r_row[7:0], r_rb);
                        {r_tlast, r_tuser} <= f_sync(r_beat, r_row, r_nb, r_y_size);
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign aclk_busy   = r_busy;
    assign aclk_done   = r_done;
    assign aclk_tvalid = r_tvalid;
    assign aclk_tdata  = r_tdata;
    assign aclk_tuser  = r_tuser;
    assign aclk_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_ramp_gen.sv
// tb_axis_ramp_gen: scoreboard bench for axis_ramp_gen; expected beats come from a
// frame-level byte model, a negedge monitor pops and compares every accepted beat.
module tb_axis_ramp_gen;

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  pw = 3'd1;
    logic [15:0] xs = '0;
    logic [15:0] ys = '0;
    logic [7:0]  gap = '0;
    logic        busy, done, tvalid, tlast;
    logic        tready = 1'b1;
    logic [63:0] tdata;
    logic [3:0]  tuser;

    axis_ramp_gen #(.MAX_X_BYTES(65536), .GAP_W(8)) dut (
        .aclk            (aclk),
        .aclk_reset_n    (rst_n),
        .aclk_start      (start),
        .aclk_pixel_width(pw),
        .aclk_x_size     (xs),
        .aclk_y_size     (ys),
        .aclk_line_gap   (gap),
        .aclk_busy       (busy),
        .aclk_done       (done),
        .aclk_tready     (tready),
        .aclk_tvalid     (tvalid),
        .aclk_tdata      (tdata),
        .aclk_tuser      (tuser),
        .aclk_tlast      (tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  user;
        logic        last;
        int          idle;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    bit    start_real = 1'b0;
    int    rdy_mode = 0;

`ifdef AXIS_RAMP_GEN_ROWID_EN
    localparam bit ROWID = 1'b1;
`else
    localparam bit ROWID = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: frame as a list of bytes per row, packed 8 per beat.
    task automatic model_frame(input int p, input int x, input int y, input int g,
                               input bit timed);
        int bpp, rb, nb, k;
        beat_t t;
        bpp = (p == 2) ? 2 : 1;
        rb  = x * bpp;
        nb  = (rb + 7) / 8;
        if (x == 0 || y == 0) begin
            done_q.push_back(1);
            return;
        end
        for (int r = 0; r < y; r++) begin
            for (int b = 0; b < nb; b++) begin
                t.data = '0;
                for (int i = 0; i < 8; i++) begin
                    k = 8 * b + i;
                    if (k < rb) t.data[8*i +: 8] = 8'(k % 256);
                end
                if (ROWID) t.data[7:0] = 8'(r % 256);
                t.user[0] = (b == 0) && (r == 0);
                t.user[2] = (b == 0) && (r != 0);
                t.user[1] = (b == nb - 1) && (r == y - 1);
                t.user[3] = (b == nb - 1) && (r != y - 1);
                t.last    = (b == nb - 1);
                t.idle    = (b == 0 && r > 0) ? g : -1;
                exp_q.push_back(t);
            end
        end
        done_q.push_back(timed ? 2 + y * nb + (y - 1) * g : -1);
    endtask

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            1:       tready = ((cyc % 8) != 7);
            2:       tready = ($urandom_range(0, 3) != 0);
            default: tready = 1'b1;
        endcase
    end

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [3:0]  prev_user;
    logic        prev_last;
    int          idle = 0;

    always @(negedge aclk) begin
        beat_t e;
        int    d;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            idle = 0;
        end else begin
            if (start && start_real) start_cyc = cyc;
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1'b1);
                check("stall_tdata", tdata, prev_data);
                check("stall_tuser", tuser, prev_user);
                check("stall_tlast", tlast, prev_last);
            end
            if (tvalid) begin
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", tdata, e.data);
                        check("tuser", tuser, e.user);
                        check("tlast", tlast, e.last);
                        if (e.idle >= 0) check("line_gap_idle", idle, e.idle);
                    end
                    idle = 0;
                end
            end else begin
                idle++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_user  = tuser;
            prev_last  = tlast;
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    d = done_q.pop_front();
                    check("beats_left_at_done", exp_q.size(), 0);
                    if (d >= 0) check("done_latency", cyc - start_cyc, d);
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge aclk);
            #1;
            if (done_q.size() == 0 && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=beats_left_%0d required=0", exp_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic run_frame(input int p, input int x, input int y, input int g,
                             input int mode, input bit timed, input bit extra_start);
        pw = 3'(p);
        xs = 16'(x);
        ys = 16'(y);
        gap = 8'(g);
        rdy_mode = mode;
        model_frame(p, x, y, g, timed);
        @(posedge aclk);
        #1;
        start = 1'b1;
        start_real = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        start_real = 1'b0;
        if (x == 0 || y == 0) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge aclk);
                #1;
                check("empty_busy", busy, 1'b0);
                check("empty_tvalid", tvalid, 1'b0);
            end
        end
        if (extra_start) begin
            repeat (4) @(posedge aclk);
            #1;
            check("busy_mid_frame", busy, 1'b1);
            xs = 16'd3;
            ys = 16'd1;
            gap = 8'd0;
            start = 1'b1;
            @(posedge aclk);
            #1;
            start = 1'b0;
        end
        wait_idle(20000);
    endtask

    task automatic reset_mid_frame();
        pw = 3'd1;
        xs = 16'd256;
        ys = 16'd4;
        gap = 8'd0;
        rdy_mode = 0;
        model_frame(1, 256, 4, 0, 1'b1);
        @(posedge aclk);
        #1;
        start = 1'b1;
        start_real = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        start_real = 1'b0;
        // beat 42 (row 1 beat 10) is on the bus during the 43rd cycle after this point
        repeat (42) @(posedge aclk);
        #2;
        check("pre_reset_tvalid", tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", tvalid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_tuser", tuser, 4'h0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge aclk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tdata", tdata, 64'h0);
        check("rst_tuser", tuser, 4'h0);
        @(posedge aclk);
        #2;
        rst_n = 1'b1;

        run_frame(1, 256, 4, 0, 0, 1'b1, 1'b0);
        run_frame(2, 13, 2, 0, 0, 1'b1, 1'b0);
        run_frame(1, 256, 4, 0, 1, 1'b0, 1'b0);
        run_frame(1, 8, 3, 5, 0, 1'b1, 1'b1);
        run_frame(1, 16, 0, 3, 0, 1'b1, 1'b0);
        run_frame(2, 0, 3, 0, 0, 1'b1, 1'b0);
        reset_mid_frame();
        run_frame(1, 24, 2, 1, 0, 1'b1, 1'b0);
        run_frame(2, 1000, 2, 2, 2, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            run_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      2, 1'b0, 1'b0);
        end

        repeat (3) @(negedge aclk);
        check("queue_empty_end", exp_q.size() + done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
